keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad scanner: drives one-hot columns, samples active-low rows,
//  debounces and encodes each press as a linear key code, and buffers codes in a small
//  FIFO with a valid/ready handshake. Sits between the board keypad pins and the
//  calculator input FSM. Column rate comes from an internal clock enable, not a derived clock.
// PARAMETERS
//  ROWS         4    number of row inputs
//  COLS         4    number of column outputs
//  SCAN_DIV     100  clk cycles per scan tick (>=2)
//  DEBOUNCE     4    consecutive ticks a state must hold to be accepted (>=1)
//  FIFO_DEPTH   4    key-code buffer entries (power of two, >=2)
//  REPEAT_DELAY 50   ticks held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE  10   ticks between further repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk        in   1                       system clock, all logic rising-edge
//  rst_n      in   1                       asynchronous active-low reset
//  row        in   ROWS                    raw row pins, active-low (0 = key closed)
//  col        out  COLS                    column drive, one-hot active-high
//  key_code   out  CW=$clog2(ROWS*COLS)    FIFO head: row_idx*COLS + col_idx
//  key_valid  out  1                       FIFO non-empty; key_code meaningful
//  key_ready  in   1                       consumer accepts head when key_valid=1
//  key_held   out  1                       debounced press currently held
//  overflow   out  1                       1-cycle pulse: code dropped, FIFO full
// BEHAVIOUR
//  - Reset: col=1 (column 0), key_valid=0, key_held=0, overflow=0, key_code=0, FIFO empty,
//    tick counter=0, FSM=SCAN. Reset mid-press discards in-progress debounce and FIFO.
//  - row passes through a 2-flop synchroniser and is inverted (1 = pressed) before use.
//  - tick: 1-cycle enable every SCAN_DIV clk; all FSM/debounce counters advance on tick only.
//  - FSM:
//    SCAN:    any synced row bit high -> DEBOUNCE, latch col index and row pattern, freeze col;
//             else rotate col left (col[COLS-1] wraps to col[0]).
//    DEBOUNCE: pattern equal to latched one for DEBOUNCE ticks -> PRESSED, push code;
//             pattern changes or goes zero -> back to SCAN (col resumes rotating).
//    PRESSED: key_held=1; all rows zero -> RELEASE. Other keys pressed meanwhile ignored.
//    RELEASE: rows zero for DEBOUNCE ticks -> SCAN, key_held=0; any row high -> PRESSED,
//             no new push (bounce on release never generates a code).
//  - Multiple rows high in one column: lowest row index wins.
//  - Latency: stable press on the active column -> push after DEBOUNCE ticks following
//    detection tick; key_valid rises the clk after the push.
//  - FIFO: pop when key_valid&&key_ready. Push while full -> code dropped, overflow pulses,
//    contents unchanged. Push and pop same cycle -> both happen (count unchanged, also when
//    full: no overflow). Pointers wrap modulo FIFO_DEPTH. key_code is registered head, stable
//    while key_valid=1 and key_ready=0.
// CONFIGURATION
//  KEYPAD_REPEAT_EN defined: in PRESSED, after REPEAT_DELAY ticks the same code is pushed
//    again, then every REPEAT_RATE ticks while held; release or reset cancels repeat.
//  KEYPAD_REPEAT_EN undefined: exactly one push per press; REPEAT_* parameters unused and
//    no repeat counter is synthesised.
// TESTING (SCAN_DIV=4, DEBOUNCE=2, defaults otherwise)
//  1 Reset: rst_n=0 mid-scan -> col=4'b0001, key_valid=0, key_held=0 immediately (async).
//  2 Press row1/col2 clean, key_ready=1 -> one code 6 with key_valid for 1 cycle; none on release.
//  3 Press row3/col0 bouncing 1 tick then stable -> exactly one code 12; glitch of 1 tick -> none.
//  4 key_ready=0, 5 distinct presses (codes 0,1,2,3,4) -> FIFO holds 0..3, overflow pulses on
//    code 4; then key_ready=1 -> 0,1,2,3 in order, key_valid drops.
//  5 Rows 0 and 2 both low on col1 -> code 1 only; second key pressed while held -> no code.
//  6 KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold code 5 for 12 ticks after accept ->
//    codes 5 at accept, +5, +7, +9, +11 ticks; undefined -> single code 5.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, debounced active-low rows, key codes into a small FIFO.
// Latency: push DEBOUNCE scan ticks after the detection tick; key_valid rises the clk after the push.
// Backpressure: key_valid/key_ready handshake; a push into a full FIFO (no pop) is dropped and pulses overflow.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 100,
    parameter int DEBOUNCE     = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int CW          = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_held,
    output logic            overflow
);
    localparam int TW   = $clog2(SCAN_DIV);
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int CIW  = $clog2(COLS);
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    if (SCAN_DIV < 2 || DEBOUNCE < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("keypad_scanner: illegal parameter combination");
    end

    typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_PRESSED, ST_RELEASE} state_t;

    logic [ROWS-1:0] row_s1_q, row_s2_q, row_act;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;

    state_t          state_q, state_d;
    logic [COLS-1:0] col_q, col_d;
    logic [CIW-1:0]  col_idx_q, col_idx_d, cur_idx;
    logic [ROWS-1:0] pat_q, pat_d;
    logic [DBW-1:0]  deb_cnt_q, deb_cnt_d;
    logic            held_q, held_d;
    logic [RIW-1:0]  row_idx;
    logic            push;
    logic [CW-1:0]   push_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW   = $clog2(RPMAX + 1);
    logic [RPW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_last;
    logic           rpt_rate_q, rpt_rate_d;
`endif

    logic [CW-1:0]   mem_q [FIFO_DEPTH];
    logic [CW-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            pop, full, do_push;

    assign row_act = ~row_s2_q;

    always_comb begin
        tick       = (tick_cnt_q == TW'(SCAN_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        col_idx_d = col_idx_q;
        pat_d     = pat_q;
        deb_cnt_d = deb_cnt_q;
        held_d    = held_q;
        push      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d  = rpt_cnt_q;
        rpt_rate_d = rpt_rate_q;
        rpt_last   = rpt_rate_q ? RPW'(REPEAT_RATE - 1) : RPW'(REPEAT_DELAY - 1);
`endif
        cur_idx = '0;
        for (int c = 0; c < COLS; c++)
            if (col_q[c]) cur_idx = CIW'(c);
        // Lowest pressed row in the latched pattern names the key.
        row_idx = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (pat_q[r]) row_idx = RIW'(r);
        push_code = CW'(int'(row_idx) * COLS + int'(col_idx_q));

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_act != '0) begin
                        state_d   = ST_DEB;
                        col_idx_d = cur_idx;
                        pat_d     = row_act;
                        deb_cnt_d = '0;
                    end else begin
                        col_d = {col_q[COLS-2:0], col_q[COLS-1]};
                    end
                end
                ST_DEB: begin
                    if (row_act != pat_q) begin
                        state_d = ST_SCAN;
                    end else if (deb_cnt_q == DBW'(DEBOUNCE - 1)) begin
                        state_d = ST_PRESSED;
                        held_d  = 1'b1;
                        push    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_d  = '0;
                        rpt_rate_d = 1'b0;
`endif
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (row_act == '0) begin
                        state_d   = ST_RELEASE;
                        deb_cnt_d = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_cnt_q == rpt_last) begin
                        push       = 1'b1;
                        rpt_cnt_d  = '0;
                        rpt_rate_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    // Release bounce falls back to PRESSED without a new code.
                    if (row_act != '0) begin
                        state_d = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_d  = '0;
                        rpt_rate_d = 1'b0;
`endif
                    end else if (deb_cnt_q == DBW'(DEBOUNCE - 1)) begin
                        state_d = ST_SCAN;
                        held_d  = 1'b0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_comb begin
        pop      = (cnt_q != '0) && key_ready;
        full     = (cnt_q == CNTW'(FIFO_DEPTH));
        do_push  = push && (!full || pop);
        ovf_d    = push && full && !pop;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_code;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q   <= '1;
            row_s2_q   <= '1;
            tick_cnt_q <= '0;
            state_q    <= ST_SCAN;
            col_q      <= COLS'(1);
            col_idx_q  <= '0;
            pat_q      <= '0;
            deb_cnt_q  <= '0;
            held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q  <= '0;
            rpt_rate_q <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            row_s1_q   <= row;
            row_s2_q   <= row_s1_q;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            col_q      <= col_d;
            col_idx_q  <= col_idx_d;
            pat_q      <= pat_d;
            deb_cnt_q  <= deb_cnt_d;
            held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_rate_q <= rpt_rate_d;
`endif
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign col       = col_q;
    assign key_code  = mem_q[rd_ptr_q];
    assign key_valid = (cnt_q != '0);
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4.
module tb_keypad_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [CW-1:0]   key_code;
    logic            key_valid, key_ready, key_held, overflow;
    logic [ROWS*COLS-1:0] key_down;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a closed switch pulls its row low while its column is driven.
    always_comb begin
        row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (key_down[r*COLS+c] && col[c]) row[r] = 1'b0;
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int got[$];
    int got_t[$];
    int vld_cycles = 0;
    int ovf_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) vld_cycles++;
            if (key_valid && key_ready) begin
                got.push_back(int'(key_code));
                got_t.push_back(cyc);
            end
            if (overflow) ovf_cnt++;
        end
    end

    typedef struct {
        logic [15:0] mask;
        int          exp_code;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [15:0] kbit(input int n);
        logic [15:0] one;
        one = 16'd1;
        return one << n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic v, input string name);
        int n;
        n = 0;
        while (key_held !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (key_held !== v) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: key_held timeout, got %b expected %b", name, key_held, v);
        end
    endtask

    task automatic clear_log();
        got.delete();
        got_t.delete();
        vld_cycles = 0;
        ovf_cnt = 0;
    endtask

    task automatic press_release(input logic [15:0] mask, input string name);
        key_down = mask;
        wait_held(1'b1, name);
        repeat (2) @(negedge clk);
        key_down = '0;
        wait_held(1'b0, name);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int rep_d[5];
        rep_d = '{0, 20, 28, 36, 44};
        vecs[0] = '{kbit(6), 6};
        vecs[1] = '{kbit(12), 12};
        vecs[2] = '{kbit(15), 15};
        vecs[3] = '{kbit(0), 0};
        vecs[4] = '{kbit(1) | kbit(9), 1};
        vecs[5] = '{kbit(3), 3};

        key_down  = '0;
        key_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col", col, 1);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", overflow, 0);
        check("rst_code", key_code, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("col_rotate", col, 2);
        repeat (12) @(negedge clk);
        check("col_wrap", col, 1);

        for (int i = 0; i < 6; i++) begin
            clear_log();
            press_release(vecs[i].mask, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_count", i), got.size(), 1);
            check($sformatf("vec%0d_code", i), got.size() > 0 ? got[0] : -1, vecs[i].exp_code);
            check($sformatf("vec%0d_vld_cycles", i), vld_cycles, 1);
        end

        clear_log();
        key_down = kbit(12);
        repeat (4) @(negedge clk);
        key_down = '0;
        repeat (80) @(negedge clk);
        check("glitch_count", got.size(), 0);

        clear_log();
        key_down = kbit(12);
        repeat (4) @(negedge clk);
        key_down = '0;
        repeat (4) @(negedge clk);
        key_down = kbit(12);
        wait_held(1'b1, "bounce_press");
        repeat (2) @(negedge clk);
        key_down = '0;
        repeat (4) @(negedge clk);
        key_down = kbit(12);
        repeat (4) @(negedge clk);
        key_down = '0;
        wait_held(1'b0, "bounce_release");
        repeat (8) @(negedge clk);
        check("bounce_count", got.size(), 1);
        check("bounce_code", got.size() > 0 ? got[0] : -1, 12);

        clear_log();
        key_down = kbit(1);
        wait_held(1'b1, "second_key");
        repeat (2) @(negedge clk);
        key_down = kbit(1) | kbit(13) | kbit(6);
        repeat (8) @(negedge clk);
        key_down = '0;
        wait_held(1'b0, "second_key_rel");
        repeat (8) @(negedge clk);
        check("second_key_count", got.size(), 1);
        check("second_key_code", got.size() > 0 ? got[0] : -1, 1);

        clear_log();
        key_ready = 1'b0;
        for (int k = 0; k < 4; k++) press_release(kbit(k), $sformatf("fifo_fill%0d", k));
        check("fifo_full_valid", key_valid, 1);
        check("fifo_full_head", key_code, 0);
        check("fifo_full_no_ovf", ovf_cnt, 0);
        press_release(kbit(4), "fifo_over");
        check("fifo_ovf_pulses", ovf_cnt, 1);
        check("fifo_head_stable", key_code, 0);
        check("fifo_no_pop", got.size(), 0);
        key_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("fifo_drain_count", got.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("fifo_drain%0d", k), got.size() > k ? got[k] : -1, k);
        check("fifo_empty_valid", key_valid, 0);

        clear_log();
        key_down = kbit(5);
        wait_held(1'b1, "repeat_press");
        repeat (47) @(negedge clk);
        key_down = '0;
        wait_held(1'b0, "repeat_release");
        repeat (8) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        check("repeat_count", got.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("repeat_code%0d", k), got.size() > k ? got[k] : -1, 5);
            check($sformatf("repeat_gap%0d", k),
                  got_t.size() > k ? got_t[k] - got_t[0] : -1, rep_d[k]);
        end
`else
        check("single_count", got.size(), 1);
        check("single_code", got.size() > 0 ? got[0] : -1, 5);
        check("single_gap_unused", rep_d[0], got_t.size() > 0 ? got_t[0] - got_t[0] : -1);
`endif

        clear_log();
        key_ready = 1'b0;
        key_down = kbit(6);
        wait_held(1'b1, "reset_press");
        repeat (2) @(negedge clk);
        check("pre_reset_valid", key_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_col", col, 1);
        check("async_rst_valid", key_valid, 0);
        check("async_rst_held", key_held, 0);
        @(negedge clk);
        key_down = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        key_ready = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_count", got.size(), 0);
        check("post_reset_valid", key_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
